// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment scan driver:
//   - SEG_OFF / AN_OFF : all-dark values for the active-low segment/anode buses
//   - HEX_SEG          : active-low segment patterns for hex 0..F (bit 0 = a,
//                        bit 6 = g)
//   - state_t          : scan FSM states (GUARD = anodes off, DRIVE = digit lit)
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10,  // 9
        7'h08,  // A
        7'h03,  // b
        7'h46,  // C
        7'h21,  // d
        7'h06,  // E
        7'h0E   // F
    };

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
// Bundles the data/strobe inputs and the display outputs of seg_scan_driver.
//   digits[15:0]  hex value, digit i = digits[4i+3:4i], digit 0 rightmost
//   dp_in[3:0]    decimal point request per digit (1 = lit)
//   blank_in[3:0] per-digit blank (1 = dark)
//   load          one-cycle strobe capturing the three fields into pending
//   seg[6:0]      active-low segments (seg[0] = a ... seg[6] = g)
//   an[3:0]       active-low anodes (an[i] low selects digit i)
//   dp            active-low decimal point
//   frame_done    one-cycle pulse during each frame-boundary cycle
// Modports: master = data source / display consumer, slave = the driver.
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;

    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_done;

    modport master (
        output digits, dp_in, blank_in, load,
        input  seg, an, dp, frame_done
    );

    modport slave (
        input  digits, dp_in, blank_in, load,
        output seg, an, dp, frame_done
    );

endinterface

// File: rtl/hex7seg_decode.sv
// -----------------------------------------------------------------------------
// hex7seg_decode
// Purely combinational hex-to-seven-segment decoder, active-low outputs.
//   i_nibble[3:0] : hex digit
//   o_seg[6:0]    : segments, bit 0 = a ... bit 6 = g, 0 = lit
// -----------------------------------------------------------------------------
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit slot is GUARD_CYCLES cycles with all anodes off followed by
// REFRESH_DIV cycles driving the digit; four slots form a frame. New values
// are captured by `load` into a pending buffer and copied into the shadow
// (displayed) buffer only on the frame-boundary cycle, so a frame never tears.
//
// Parameters:
//   REFRESH_DIV  (>= 1) drive cycles per digit slot
//   GUARD_CYCLES (>= 0) blank cycles before each digit; 0 removes GUARD
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          seg_scan_driver_if.slave (digits/dp_in/blank_in/load in,
//                seg/an/dp/frame_done out, all outputs registered)
// Configuration macro:
//   SEG_LEADING_ZERO_BLANK_EN  when defined, leading zeros of the shadow
//                              value are darkened (digit 0 never), ORed with
//                              the shadow blank mask.
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input logic              clk,
    input logic              rst_n,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned CNT_MAX  = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int unsigned CNT_SPAN = (CNT_MAX < 2) ? 2 : CNT_MAX;
    localparam int unsigned CW       = $clog2(CNT_SPAN);

    localparam logic [CW-1:0] DRIVE_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST  = CW'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
    localparam state_t        RESET_STATE = (GUARD_CYCLES == 0) ? DRIVE : GUARD;

    // Scan state
    state_t          r_state;
    logic [1:0]      r_idx;
    logic [CW-1:0]   r_cnt;

    // Pending (written by load) and shadow (displayed) buffers
    logic [15:0]     r_pend_digits;
    logic [3:0]      r_pend_dp;
    logic [3:0]      r_pend_blank;
    logic            r_pend_valid;
    logic [15:0]     r_shad_digits;
    logic [3:0]      r_shad_dp;
    logic [3:0]      r_shad_blank;

    // Registered outputs
    logic [6:0]      r_seg;
    logic [3:0]      r_an;
    logic            r_dp;
    logic            r_frame_done;

    // Next-cycle values
    logic            w_leave;
    logic            w_boundary;
    state_t          w_next_state;
    logic [1:0]      w_next_idx;
    logic [CW-1:0]   w_next_cnt;
    logic [15:0]     w_next_digits;
    logic [3:0]      w_next_dp;
    logic [3:0]      w_next_blank;
    logic [3:0]      w_dark;
    logic [3:0]      w_nibble;
    logic [6:0]      w_dec_seg;
    logic [6:0]      w_out_seg;
    logic [3:0]      w_out_an;
    logic            w_out_dp;
    logic            w_out_fd;

    // Outputs are registered from the *next* state/idx/shadow so they change
    // on the same edge as the state itself; the decoder therefore looks at
    // the digit that will be shown in the coming cycle.
    hex7seg_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        w_next_state  = r_state;
        w_next_idx    = r_idx;
        w_next_cnt    = r_cnt + CW'(1);
        w_next_digits = r_shad_digits;
        w_next_dp     = r_shad_dp;
        w_next_blank  = r_shad_blank;
        w_out_seg     = SEG_OFF;
        w_out_an      = AN_OFF;
        w_out_dp      = 1'b1;

        w_leave    = (r_state == DRIVE) ? (r_cnt == DRIVE_LAST) : (r_cnt == GUARD_LAST);
        w_boundary = (r_state == DRIVE) && w_leave && (r_idx == 2'd3);

        if (w_leave) begin
            w_next_cnt = '0;
            if (r_state == DRIVE) begin
                w_next_idx   = r_idx + 2'd1;
                w_next_state = (GUARD_CYCLES == 0) ? DRIVE : GUARD;
            end else begin
                w_next_state = DRIVE;
            end
        end

        // Pending contents apply at the boundary; a load in this same cycle
        // only refreshes pending and waits for the following boundary.
        if (w_boundary && r_pend_valid) begin
            w_next_digits = r_pend_digits;
            w_next_dp     = r_pend_dp;
            w_next_blank  = r_pend_blank;
        end

`ifdef SEG_LEADING_ZERO_BLANK_EN
        w_dark[3] = (w_next_digits[15:12] == 4'h0);
        w_dark[2] = w_dark[3] && (w_next_digits[11:8] == 4'h0);
        w_dark[1] = w_dark[2] && (w_next_digits[7:4] == 4'h0);
        w_dark[0] = 1'b0;
        w_dark    = w_dark | w_next_blank;
`else
        w_dark = w_next_blank;
`endif

        w_nibble = w_next_digits[{w_next_idx, 2'b00} +: 4];

        if ((w_next_state == DRIVE) && !w_dark[w_next_idx]) begin
            w_out_seg = w_dec_seg;
            w_out_an  = ~(4'b0001 << w_next_idx);
            w_out_dp  = ~w_next_dp[w_next_idx];
        end

        // Raise frame_done for the boundary cycle itself: the cycle that will
        // be the last DRIVE cycle of digit 3.
        w_out_fd = (w_next_state == DRIVE) && (w_next_idx == 2'd3) && (w_next_cnt == DRIVE_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffers are a handful of flops, not a RAM, so they are
            // reset with everything else; mid-operation reset drops pending data.
            r_state       <= RESET_STATE;
            r_idx         <= 2'd0;
            r_cnt         <= '0;
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_blank  <= '0;
            r_pend_valid  <= 1'b0;
            r_shad_digits <= '0;
            r_shad_dp     <= '0;
            r_shad_blank  <= 4'b1111;
            r_seg         <= SEG_OFF;
            r_an          <= AN_OFF;
            r_dp          <= 1'b1;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_idx         <= w_next_idx;
            r_cnt         <= w_next_cnt;
            r_shad_digits <= w_next_digits;
            r_shad_dp     <= w_next_dp;
            r_shad_blank  <= w_next_blank;
            r_seg         <= w_out_seg;
            r_an          <= w_out_an;
            r_dp          <= w_out_dp;
            r_frame_done  <= w_out_fd;

            if (bus.load) begin
                r_pend_digits <= bus.digits;
                r_pend_dp     <= bus.dp_in;
                r_pend_blank  <= bus.blank_in;
                r_pend_valid  <= 1'b1;
            end else if (w_boundary) begin
                r_pend_valid  <= 1'b0;
            end
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Scoreboard bench for seg_scan_driver with REFRESH_DIV=4, GUARD_CYCLES=2
// (6-cycle slot, 24-cycle frame). The stimulus process applies inputs just
// after each rising edge and pushes the expected display state for that cycle,
// derived from a cycle-count model of the frame (slot position, digit number,
// shadow/pending buffers). A monitor pops and compares on each falling edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int RD    = 4;
    localparam int GC    = 2;
    localparam int SLOT  = RD + GC;
    localparam int FRAME = 4 * SLOT;

    // Lit segments, active-high, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] LIT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
        logic       fd;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   mon_cycle   = 0;

    // Reference model: cycle k counted from reset release
    int          k;
    logic [15:0] sh_d, pd_d;
    logic [3:0]  sh_dp, pd_dp, sh_bl, pd_bl;
    bit          pv;

    function automatic bit auto_dark(input int d);
        bit z;
        z = 1'b0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (d != 0) begin
            z = 1'b1;
            for (int j = d; j <= 3; j++)
                if (sh_d[4*j +: 4] != 4'h0) z = 1'b0;
        end
`endif
        return z;
    endfunction

    function automatic obs_t expect_now();
        obs_t e;
        int   pos;
        int   d;
        logic [3:0] one;
        one = 4'b0001;
        pos = k % SLOT;
        d   = (k / SLOT) % 4;
        e.seg = 7'h7F;
        e.an  = 4'hF;
        e.dp  = 1'b1;
        e.fd  = ((k % FRAME) == FRAME - 1);
        if (pos >= GC && !sh_bl[d] && !auto_dark(d)) begin
            e.an  = ~(one << d);
            e.seg = ~LIT[sh_d[4*d +: 4]];
            e.dp  = ~sh_dp[d];
        end
        return e;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got seg=%h an=%b dp=%b fd=%b, expected seg=%h an=%b dp=%b fd=%b",
                     name, got.seg, got.an, got.dp, got.fd, exp.seg, exp.an, exp.dp, exp.fd);
        end
    endtask

    // Monitor: one observation per cycle, mid-cycle
    always @(negedge clk) begin
        obs_t got;
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = '{seg: bus.seg, an: bus.an, dp: bus.dp, fd: bus.frame_done};
            check($sformatf("cycle%0d", mon_cycle), got, e);
        end
        mon_cycle++;
    end

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        bus.load = 1'b0;
        exp_q.push_back('{seg: 7'h7F, an: 4'hF, dp: 1'b1, fd: 1'b0});
        k     = 0;
        sh_d  = '0;
        sh_dp = '0;
        sh_bl = 4'b1111;
        pd_d  = '0;
        pd_dp = '0;
        pd_bl = '0;
        pv    = 1'b0;
    endtask

    task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.load     = ld;
        bus.digits   = d;
        bus.dp_in    = dpv;
        bus.blank_in = bl;
        exp_q.push_back(expect_now());
        if ((k % FRAME) == FRAME - 1 && pv) begin
            sh_d  = pd_d;
            sh_dp = pd_dp;
            sh_bl = pd_bl;
            pv    = 1'b0;
        end
        if (ld) begin
            pd_d  = d;
            pd_dp = dpv;
            pd_bl = bl;
            pv    = 1'b1;
        end
        k++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic run_until(input int phase);
        for (int i = 0; i < FRAME && (k % FRAME) != phase; i++) idle(1);
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.digits   = '0;
        bus.dp_in    = '0;
        bus.blank_in = '0;

        // Reset and idle: dark, frame_done every 24 cycles
        reset_cycle();
        idle(50);

        // Basic scan 12A8, dp on digit 1
        step(1'b1, 16'h12A8, 4'b0010, 4'b0000);
        idle(2 * FRAME);

        // Double load before one boundary: only 2222 shows
        run_until(0);
        step(1'b1, 16'h1111, 4'b0000, 4'b0000);
        idle(4);
        step(1'b1, 16'h2222, 4'b0000, 4'b0000);
        idle(2 * FRAME);

        // Boundary collision: 4444 pending, 3333 loaded on the boundary cycle
        run_until(5);
        step(1'b1, 16'h4444, 4'b0001, 4'b0000);
        run_until(FRAME - 1);
        step(1'b1, 16'h3333, 4'b1000, 4'b0000);
        idle(2 * FRAME + 2);

        // Leading zeros (blanked only when the macro is defined)
        step(1'b1, 16'h0050, 4'b0000, 4'b0000);
        idle(2 * FRAME);

        // Explicit blanking of digits 0 and 2
        step(1'b1, 16'hFEDC, 4'b1111, 4'b0101);
        idle(2 * FRAME);

        // Mid-frame reset while digit 2 is driven, then stays dark
        run_until(15);
        reset_cycle();
        idle(2 * FRAME);
        step(1'b1, 16'h9B07, 4'b0100, 4'b0000);
        idle(2 * FRAME);

        // Randomised loads at random times
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0)
                step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
            else
                idle(1);
        end

        // Drain: every pushed expectation must have been consumed
        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
